// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state, Booth digit type and digit-count helper for the Booth multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} multState_t;
    typedef logic signed [2:0] boothDigit_t;
    function automatic int ndig(input int w);
        return (w + 3) / 2;
    endfunction
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps a radix-4 Booth triplet {b(2i+1), b(2i), b(2i-1)} to neg/zero/two select lines.
module booth_recoder (
    input  logic [2:0] triplet_i,
    output logic       neg_o,
    output logic       zero_o,
    output logic       two_o
);
    always_comb begin
        zero_o = (triplet_i == 3'b000) || (triplet_i == 3'b111);
        two_o  = (triplet_i == 3'b011) || (triplet_i == 3'b100);
        neg_o  = triplet_i[2] & ~(triplet_i[1] & triplet_i[0]);
    end
endmodule

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: iterative unsigned radix-4 Booth multiplier, one digit per cycle, start/done handshake.
// Define BOOTH_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module booth_radix4_mult
    import mult_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int OUTWIDTH = 2 * WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    mulIn1,
    input  logic [WIDTH-1:0]    mulIn2,
    output logic [OUTWIDTH-1:0] mulOut,
    output logic                done
);
    localparam int NDIG = ndig(WIDTH);
    localparam int AW   = 2 * WIDTH + 2;
    localparam int MW   = 2 * NDIG;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    multState_t            state_q;
    logic signed [AW-1:0]  mcand_q, acc_q, acc_d, mult_d, pp_d;
    logic [MW-1:0]         mplr_q;
    logic                  prev_q;
    logic [CW-1:0]         cnt_q;
    logic [OUTWIDTH-1:0]   mul_out_q;
    logic                  done_q, last_d, neg, zero, two;

    booth_recoder u_rec (
        .triplet_i({mplr_q[1:0], prev_q}),
        .neg_o    (neg),
        .zero_o   (zero),
        .two_o    (two)
    );

    // Multiplicand is pre-shifted by 2 per digit, so digit i always adds at bit 0 of mcand_q.
    always_comb begin
        mult_d = two ? (mcand_q <<< 1) : mcand_q;
        pp_d   = zero ? '0 : (neg ? -mult_d : mult_d);
        acc_d  = acc_q + pp_d;
`ifdef BOOTH_MULT_EARLY_TERM_EN
        last_d = (cnt_q == LAST) || ~|mplr_q[MW-1:1];
`else
        last_d = (cnt_q == LAST);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            prev_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mul_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                BUSY: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q <<< 2;
                    mplr_q  <= mplr_q >> 2;
                    prev_q  <= mplr_q[1];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_d) begin
                        state_q   <= DONE;
                        mul_out_q <= acc_d[OUTWIDTH-1:0];
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= BUSY;
                        mcand_q <= AW'(mulIn1);
                        mplr_q  <= MW'(mulIn2);
                        prev_q  <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mulOut = mul_out_q;
    assign done   = done_q;
endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: scoreboard bench; stimulus pushes expected product and done cycle, monitor pops on done.
module tb_booth_radix4_mult;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  mulIn1 = '0;
    logic [9:0]  mulIn2 = '0;
    logic [19:0] mulOut;
    logic        done;

    typedef struct {
        logic [19:0] p;
        int          c;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [19:0] last_out = '0;

    booth_radix4_mult #(.WIDTH(10)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .mulIn1(mulIn1),
        .mulIn2(mulIn2),
        .mulOut(mulOut),
        .done  (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat(input logic [9:0] b);
`ifdef BOOTH_MULT_EARLY_TERM_EN
        for (int k = 1; k < 6; k++)
            if ((b >> (2 * k - 1)) == 10'd0) return k + 1;
        return 7;
`else
        return 7;
`endif
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            last_out = mulOut;
        end else if (done) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: cycle %0d mulOut=%h, no done expected", cyc, mulOut);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (mulOut !== e.p) begin
                    fails++;
                    $display("FAIL product: got %h expected %h (cycle %0d)", mulOut, e.p, cyc);
                end
                checks++;
                if (cyc != e.c) begin
                    fails++;
                    $display("FAIL done_cycle: got cycle %0d expected cycle %0d", cyc, e.c);
                end
            end
            last_out = mulOut;
        end else begin
            checks++;
            if (mulOut !== last_out) begin
                fails++;
                $display("FAIL stable: mulOut=%h changed from %h without done (cycle %0d)", mulOut, last_out, cyc);
            end
        end
    end

    task automatic issue(input logic [9:0] a, input logic [9:0] b, input logic [19:0] expv);
        exp_t e;
        mulIn1 = a;
        mulIn2 = b;
        start  = 1'b1;
        e.p = expv;
        e.c = cyc + lat(b);
        q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL timeout: %0d results still pending after 100 cycles", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [9:0] a, b;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        issue(10'h100, 10'h200, 20'h20000);
        drain();
        issue(10'h3FF, 10'h3FF, 20'hFF801);
        drain();
        issue(10'h000, 10'h3FF, 20'h00000);
        drain();
        issue(10'h155, 10'h001, 20'h00155);
        drain();
        issue(10'h2AA, 10'h155, 20'h38C72);
        drain();
        issue(10'h200, 10'h3FF, 20'h7FE00);
        drain();
        issue(10'h3FF, 10'h000, 20'h00000);
        drain();
        // back-to-back: second start lands in the DONE cycle of the first
        issue(10'h3FF, 10'h3FF, 20'hFF801);
        repeat (6) @(negedge clock);
        issue(10'h0FF, 10'h002, 20'h001FE);
        drain();
        // start during BUSY must be ignored
        issue(10'h3FF, 10'h3FF, 20'hFF801);
        @(negedge clock);
        mulIn1 = 10'h123;
        mulIn2 = 10'h045;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();
        // asynchronous reset mid-operation
        issue(10'h2AA, 10'h3FF, 20'h0);
        @(negedge clock);
        #2;
        reset  = 1'b0;
        mulIn1 = 10'($urandom);
        mulIn2 = 10'($urandom);
        start  = 1'($urandom);
        #1;
        q.delete();
        checks++;
        if (mulOut !== 20'h0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: mulOut=%h done=%b, required 0 and 0", mulOut, done);
        end
        repeat (2) @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        repeat (20) @(negedge clock);
        for (int i = 0; i < 400; i++) begin
            a = 10'($urandom);
            b = (i % 4 == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
            issue(a, b, 20'(a) * 20'(b));
            if (i % 3 == 0) drain();
            else while (q.size() != 0) @(negedge clock);
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
